// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle for the sequential ALU.
//   valid_i    request strobe (master -> ALU)
//   ALUCtrl_i  4-bit operation code
//   src1_i     operand A
//   src2_i     operand B
//   ready_o    ALU can accept a request this cycle
//   valid_o    one-cycle pulse marking result_o/zero_o/overflow_o valid
//   result_o   registered result
//   zero_o     registered result-is-zero flag
//   overflow_o registered signed overflow (add/sub only)
interface seq_alu_if #(
  parameter int DATA_W = 32
);
  logic              valid_i;
  logic [3:0]        ALUCtrl_i;
  logic [DATA_W-1:0] src1_i;
  logic [DATA_W-1:0] src2_i;
  logic              ready_o;
  logic              valid_o;
  logic [DATA_W-1:0] result_o;
  logic              zero_o;
  logic              overflow_o;

  modport master (
    output valid_i, ALUCtrl_i, src1_i, src2_i,
    input  ready_o, valid_o, result_o, zero_o, overflow_o
  );

  modport slave (
    input  valid_i, ALUCtrl_i, src1_i, src2_i,
    output ready_o, valid_o, result_o, zero_o, overflow_o
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: ALU with single-cycle logic/arithmetic ops and an iterative
// shift-add multiplier (one multiplier bit per clock, LSB first).
//   clk_i  system clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    seq_alu_if slave: valid_i/ALUCtrl_i/src1_i/src2_i in,
//          ready_o/valid_o/result_o/zero_o/overflow_o out
module seq_alu #(
  parameter int DATA_W = 32
) (
  input  logic    clk_i,
  input  logic    rst_i,
  seq_alu_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MULT = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1111;

  // Signed overflow: same-sign operands (add) or different-sign operands
  // (sub) whose result sign departs from operand A.
  function automatic logic add_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] r);
    return (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] r);
    return (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
  endfunction

  logic [0:0]               state_q,  state_d;
  logic [CNT_W-1:0]         cnt_q,    cnt_d;
  logic [DATA_W-1:0]        mcand_q,  mcand_d;
  logic [DATA_W-1:0]        mplier_q, mplier_d;
  logic [DATA_W-1:0]        acc_q,    acc_d;
  logic [DATA_W-1:0]        result_q, result_d;
  logic                     zero_q,   zero_d;
  logic                     ovf_q,    ovf_d;
  logic                     valid_q,  valid_d;

  logic signed [DATA_W-1:0] src_a, src_b, sum, diff;
  logic [DATA_W-1:0]        alu_res;
  logic                     alu_ovf;
  logic [DATA_W-1:0]        acc_sum;

  // Single-cycle datapath
  always_comb begin
    src_a   = bus.src1_i;
    src_b   = bus.src2_i;
    sum     = src_a + src_b;
    diff    = src_a - src_b;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.ALUCtrl_i)
      OP_AND: alu_res = bus.src1_i & bus.src2_i;
      OP_OR:  alu_res = bus.src1_i | bus.src2_i;
      OP_XOR: alu_res = bus.src1_i ^ bus.src2_i;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = add_ovf(src_a, src_b, sum);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = sub_ovf(src_a, src_b, diff);
      end
      OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, (src_a < src_b)};
      default: alu_res = '0;
    endcase
  end

  // Control and multiplier iteration
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          if (bus.ALUCtrl_i == OP_MULT) begin
            mcand_d  = bus.src1_i;
            mplier_d = bus.src2_i;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            valid_d  = 1'b1;
          end
        end
      end
      MUL: begin
        // Low DATA_W bits only, so the same shift-add serves signed and unsigned.
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          result_d = acc_sum;
          zero_d   = (acc_sum == '0);
          ovf_d    = 1'b0;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.ready_o    = (state_q == IDLE);
  assign bus.valid_o    = valid_q;
  assign bus.result_o   = result_q;
  assign bus.zero_o     = zero_q;
  assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  localparam int DATA_W = 32;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  seq_alu_if #(.DATA_W(DATA_W)) bus ();

  seq_alu #(.DATA_W(DATA_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    bus.valid_i   = v;
    bus.ALUCtrl_i = op;
    bus.src1_i    = a;
    bus.src2_i    = b;
  endtask

  // Issue one op at the next edge and check the registered result after it.
  task automatic single(input string tag, input logic [3:0] op,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [DATA_W-1:0] exp, input logic ez, input logic eo);
    drive(1'b1, op, a, b);
    @(negedge clk_i);
    chk({tag, "_vld"}, DATA_W'(bus.valid_o), 1);
    chk({tag, "_res"}, bus.result_o, exp);
    chk({tag, "_zero"}, DATA_W'(bus.zero_o), DATA_W'(ez));
    chk({tag, "_ovf"}, DATA_W'(bus.overflow_o), DATA_W'(eo));
  endtask

  // Issue a MULT, optionally pester with ADD requests while busy, and check
  // latency, busy behaviour and the result.
  task automatic mult(input string tag, input logic [DATA_W-1:0] a,
                      input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] exp,
                      input logic ez, input logic junk);
    int n;
    int bad;
    drive(1'b1, 4'b0011, a, b);
    @(negedge clk_i);
    n = 1;
    bad = 0;
    while (!bus.valid_o && n < 40) begin
      if (bus.ready_o) bad++;
      drive(junk && n < 30, 4'b0010, 32'd1, 32'd1);
      @(negedge clk_i);
      n++;
    end
    drive(1'b0, 4'b0000, '0, '0);
    chk({tag, "_lat"}, DATA_W'(n), 33);
    chk({tag, "_busy"}, DATA_W'(bad), 0);
    chk({tag, "_rdy"}, DATA_W'(bus.ready_o), 1);
    chk({tag, "_res"}, bus.result_o, exp);
    chk({tag, "_zero"}, DATA_W'(bus.zero_o), DATA_W'(ez));
    chk({tag, "_ovf"}, DATA_W'(bus.overflow_o), 0);
  endtask

  initial begin
    int seen;
    drive(1'b0, 4'b0000, '0, '0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_rdy", DATA_W'(bus.ready_o), 1);
    chk("rst_vld", DATA_W'(bus.valid_o), 0);
    chk("rst_res", bus.result_o, 0);
    chk("rst_zero", DATA_W'(bus.zero_o), 1);
    chk("rst_ovf", DATA_W'(bus.overflow_o), 0);

    single("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
    single("sub_zero", 4'b0110, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0);
    single("sub_ovf", 4'b0110, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    drive(1'b0, 4'b0000, '0, '0);
    @(negedge clk_i);
    chk("idle_vld", DATA_W'(bus.valid_o), 0);
    chk("idle_hold", bus.result_o, 32'h7FFF_FFFF);

    single("and", 4'b0000, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b0);
    single("or", 4'b0001, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0, 1'b0);
    single("xor", 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    single("slt_t", 4'b0111, 32'hFFFF_FFFD, 32'd2, 32'h1, 1'b0, 1'b0);
    single("slt_f", 4'b0111, 32'd2, 32'hFFFF_FFFD, 32'h0, 1'b1, 1'b0);
    single("badop", 4'b0100, 32'h1234, 32'h5678, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 4'b0000, '0, '0);
    @(negedge clk_i);
    chk("b2b_end_vld", DATA_W'(bus.valid_o), 0);

    mult("mul_neg", 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b1);
    @(negedge clk_i);
    chk("mul_after_vld", DATA_W'(bus.valid_o), 0);
    chk("mul_after_hold", bus.result_o, 32'hFFFF_FFEB);

    mult("mul_zero", 32'h1_0000, 32'h1_0000, 32'h0, 1'b1, 1'b0);
    mult("mul_b2b", 32'hFFFF, 32'hFFFF, 32'hFFFE_0001, 1'b0, 1'b0);

    // Abort a multiply with reset at the tenth edge after acceptance.
    drive(1'b1, 4'b0011, 32'd5, 32'd5);
    @(negedge clk_i);
    drive(1'b0, 4'b0000, '0, '0);
    repeat (9) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("abort_vld", DATA_W'(bus.valid_o), 0);
    chk("abort_rdy", DATA_W'(bus.ready_o), 1);
    chk("abort_res", bus.result_o, 0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (bus.valid_o) seen++;
    end
    chk("abort_nopulse", DATA_W'(seen), 0);

    // Reset coincident with a request discards it.
    rst_i = 1'b1;
    drive(1'b1, 4'b0010, 32'd1, 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_req_vld", DATA_W'(bus.valid_o), 0);
    chk("rst_req_res", bus.result_o, 0);
    single("add_post_rst", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);
    drive(1'b0, 4'b0000, '0, '0);
    @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
